// File: rtl/s3g_defs_pkg.sv
// -----------------------------------------------------------------------------
// s3g_defs
// Shared definitions for the S3G packet transmitter and receiver:
//   - S3G_HDR       : start-of-packet byte
//   - S3G_CRC_POLY  : reflected Maxim/iButton CRC8 polynomial
//   - s3g_state_e   : sender FSM state encoding
//   - crc8_step     : folds one byte into a running CRC8 value
// -----------------------------------------------------------------------------
package s3g_defs;

  localparam logic [7:0] S3G_HDR      = 8'hD5;
  localparam logic [7:0] S3G_CRC_POLY = 8'h8C;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } s3g_state_e;

  // Maxim/iButton CRC8, LSB-first: xor the byte in, then shift eight times,
  // folding the polynomial back in whenever a 1 falls off the bottom.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc_in,
                                           input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ S3G_CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/s3g_crc8.sv
// -----------------------------------------------------------------------------
// s3g_crc8
// Registered byte-accumulating Maxim CRC8 (init 0x00).
// Ports:
//   clk      in   system clock
//   rst      in   synchronous reset, active-high (crc -> 0)
//   clr      in   restart accumulation (crc -> 0); wins over en
//   en       in   fold data_in into the running CRC this cycle
//   data_in  in   byte to accumulate
//   crc_out  out  current CRC value (registered)
// -----------------------------------------------------------------------------
module s3g_crc8
  import s3g_defs::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  // NOTE: every variable assigned in an always_comb gets a default on entry so
  // that no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = 8'h00;
    end else if (en) begin
      crc_d = crc8_step(crc_q, data_in);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/s3g_pkt_sender.sv
// -----------------------------------------------------------------------------
// s3g_pkt_sender
// Buffers a payload loaded byte-by-byte, then on start emits
//   HDR_BYTE, len, payload[0..len-1], CRC8(payload)
// over the tx_data/tx_wr/tx_done handshake of uart_transceiver, with an
// optional idle gap after each byte, repeat count and CRC corruption.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   ld_data/ld_wr  append one payload byte (IDLE only, while not full)
//   ld_full        buffer holds MAX_LEN bytes
//   ld_clear       discard payload and clear overflow (IDLE only)
//   start          begin transmission (ignored while busy)
//   repeat_cnt     extra retransmissions, latched at start
//   gap_cycles     idle clocks after each tx_done, latched at start
//   crc_corrupt    send ~CRC instead of CRC, latched at start
//   tx_data/tx_wr  byte and one-cycle write strobe towards the UART
//   tx_done        UART finished the current byte
//   busy           packet(s) in flight
//   done           one-cycle pulse after the final CRC byte's tx_done
//   overflow       sticky: a load was dropped (full or busy)
// -----------------------------------------------------------------------------
module s3g_pkt_sender
  import s3g_defs::*;
#(
  parameter int         MAX_LEN  = 32,
  parameter int         GAP_W    = 16,
  parameter logic [7:0] HDR_BYTE = S3G_HDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ld_data,
  input  logic             ld_wr,
  output logic             ld_full,
  input  logic             ld_clear,
  input  logic             start,
  input  logic [7:0]       repeat_cnt,
  input  logic [GAP_W-1:0] gap_cycles,
  input  logic             crc_corrupt,
  output logic [7:0]       tx_data,
  output logic             tx_wr,
  input  logic             tx_done,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  s3g_state_e       state_q,    state_d;
  logic [8:0]       idx_q,      idx_d;
  logic [7:0]       len_q,      len_d;
  logic [7:0]       rpt_q,      rpt_d;
  logic [GAP_W-1:0] gap_q,      gap_d;
  logic [GAP_W-1:0] gcnt_q,     gcnt_d;
  logic             corrupt_q,  corrupt_d;
  logic [7:0]       tx_data_q,  tx_data_d;
  logic             tx_wr_q,    tx_wr_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic             overflow_q, overflow_d;

  logic [7:0]    mem [MAX_LEN];
  logic [7:0]    crc;
  logic [7:0]    byte_sel;
  logic [AW-1:0] rd_addr;
  logic [8:0]    last_idx;
  logic          idle;
  logic          load_ok;
  logic          clear_ok;
  logic          ovf_set;
  logic          advance;

  // ---------------------------------------------------------------------------
  // Load path
  // ---------------------------------------------------------------------------
  assign idle     = (state_q == ST_IDLE);
  assign ld_full  = (len_q == MAX_LEN_B);
  // ld_clear takes priority over a simultaneous ld_wr: the byte is dropped.
  assign clear_ok = idle & ld_clear;
  assign load_ok  = idle & ld_wr & ~ld_clear & ~ld_full;
  assign ovf_set  = ld_wr & (ld_full | busy_q);

  always_comb begin
    len_d      = len_q;
    overflow_d = overflow_q;
    if (clear_ok) begin
      len_d      = 8'd0;
      overflow_d = 1'b0;
    end else begin
      if (load_ok) begin
        len_d = len_q + 8'd1;
      end
      if (ovf_set) begin
        overflow_d = 1'b1;
      end
    end
  end

  // NOTE: the payload RAM carries no reset; len_q alone defines which entries
  // are valid, and leaving storage unreset lets it map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[AW'(len_q)] <= ld_data;
    end
  end

  // CRC follows the payload as it is loaded, so it is ready before start.
  s3g_crc8 u_crc (
    .clk     (clk),
    .rst     (rst),
    .clr     (clear_ok),
    .en      (load_ok),
    .data_in (ld_data),
    .crc_out (crc)
  );

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  // Index of the CRC byte; 9 bits so len=255 does not wrap.
  assign last_idx = {1'b0, len_q} + 9'd2;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rpt_d     = rpt_q;
    gap_d     = gap_q;
    gcnt_d    = gcnt_q;
    corrupt_d = corrupt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    advance   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ISSUE;
          busy_d    = 1'b1;
          idx_d     = 9'd0;
          rpt_d     = repeat_cnt;
          gap_d     = gap_cycles;
          corrupt_d = crc_corrupt;
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (tx_done) begin
          if (idx_q == last_idx) begin
            if (rpt_q != 8'd0) begin
              rpt_d   = rpt_q - 8'd1;
              idx_d   = 9'd0;
              advance = 1'b1;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 9'd1;
            advance = 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (gcnt_q == '0) begin
          state_d = ST_ISSUE;
        end else begin
          gcnt_d = gcnt_q - GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Moving on to the next byte: the GAP state is occupied for exactly
    // gap_q cycles, so the counter starts at gap_q - 1.
    if (advance) begin
      if (gap_q != '0) begin
        state_d = ST_GAP;
        gcnt_d  = gap_q - GAP_W'(1);
      end else begin
        state_d = ST_ISSUE;
      end
    end
  end

  // Byte to present for the index being entered. Only the header is read at
  // the start edge, so a load coincident with start is already in len_q by the
  // time the length byte is selected.
  assign rd_addr = AW'(idx_d - 9'd2);

  always_comb begin
    byte_sel = 8'h00;
    if (idx_d == 9'd0) begin
      byte_sel = HDR_BYTE;
    end else if (idx_d == 9'd1) begin
      byte_sel = len_q;
    end else if (idx_d < last_idx) begin
      byte_sel = mem[rd_addr];
    end else begin
      byte_sel = crc ^ {8{corrupt_d}};
    end
  end

  // tx_wr is registered: it is high for exactly the one cycle spent in ISSUE.
  assign tx_wr_d   = (state_d == ST_ISSUE);
  assign tx_data_d = tx_wr_d ? byte_sel : tx_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= 9'd0;
      len_q      <= 8'd0;
      rpt_q      <= 8'd0;
      gap_q      <= '0;
      gcnt_q     <= '0;
      corrupt_q  <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_wr_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      rpt_q      <= rpt_d;
      gap_q      <= gap_d;
      gcnt_q     <= gcnt_d;
      corrupt_q  <= corrupt_d;
      tx_data_q  <= tx_data_d;
      tx_wr_q    <= tx_wr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_wr    = tx_wr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule
